// File: rtl/restoring_divider_16_pkg.sv
// Shared types and widths for the 16-bit restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FINISH
    } state_t;

endpackage

// File: rtl/restoring_divider_16_if.sv
// Run/Done handshake and operand/result buses of the restoring divider.
interface restoring_divider_16_if #(
    parameter int unsigned WIDTH = div_pkg::DIV_WIDTH
);

    logic             Run;
    logic [WIDTH-1:0] Dividend;
    logic [WIDTH-1:0] Divisor;
    logic [WIDTH-1:0] Quotient;
    logic [WIDTH-1:0] Remainder;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Run, Dividend, Divisor,
        input  Quotient, Remainder, Busy, Done, DivByZero
    );

    modport slave (
        input  Run, Dividend, Divisor,
        output Quotient, Remainder, Busy, Done, DivByZero
    );

endinterface

// File: rtl/restoring_divider_16_trial_subtractor.sv
// Combinational trial subtraction a - b as a + ~b + 1; borrow is the inverted carry out.
module trial_subtractor #(
    parameter int unsigned WIDTH = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign diff   = sum[WIDTH-1:0];
    assign borrow = ~sum[WIDTH];

endmodule

// File: rtl/restoring_divider_16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock under a Run/Done handshake.
module restoring_divider_16
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input logic                   Clk,
    input logic                   Reset,
    restoring_divider_16_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;

    // r never exceeds the divisor, so its top bit is always shifted out here
    assign shifted = (r << 1) | (WIDTH + 1)'(q[WIDTH-1]);

    trial_subtractor #(
        .WIDTH(WIDTH + 1)
    ) u_trial (
        .a     (shifted),
        .b     ({1'b0, d}),
        .diff  (trial),
        .borrow(borrow)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Run) begin
                        d           <= bus.Divisor;
                        q           <= bus.Dividend;
                        r           <= '0;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (bus.Divisor == '0) ? FINISH : ITER;
                    end
                end
                ITER: begin
                    r     <= borrow ? shifted : trial;
                    q     <= {q[WIDTH-2:0], ~borrow};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // d can only be zero here via the divide-by-zero shortcut from IDLE
                    if (d == '0) begin
                        quotient    <= '1;
                        remainder   <= q;
                        div_by_zero <= 1'b1;
                    end else begin
                        quotient  <= q;
                        remainder <= r[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Quotient  = quotient;
    assign bus.Remainder = remainder;
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.DivByZero = div_by_zero;

endmodule
